line_window_3x3: RTL and testbench
==================================

# line_window_3x3

Builds a 3×3 pixel neighbourhood from a raster pixel stream so downstream filters (Sobel, median, Gaussian) can read a full window every pixel. It is the reader side of the line-delay memory. It writes each incoming pixel into two cascaded line delays and reads back the two previous rows. It then aligns the three rows through column shift registers. It sits between the pixel source and any 3×3 kernel block in the image pipeline.

## Interface
Parameters:
- MAX_WIDTH, 640: maximum line length (pixels); sizes line-delay storage.
- DATA_W, 8: pixel width in bits.

Ports:
- clock  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- img_width  in  16  active line length in pixels.
  - Sampled on the in_vsync rising edge.
  - Legal range 2..MAX_WIDTH.
- in_vsync  in  1  frame sync, high during the active frame.
- in_href  in  1  line valid.
- in_clken  in  1  pixel strobe, one per valid pixel.
- in_data  in  DATA_W  pixel value.
- out_vsync, out_href, out_clken  out  1 each  inputs delayed by exactly 1 cycle.
- p11..p33  out  DATA_W each  window taps.
  - Row 1 is the oldest line; column 1 is the oldest pixel.
  - p33 is the most recent pixel.
- out_win_valid  out  1  high with out_clken when the window lies fully inside the frame.

## Operation
- Line delays:
  - row3 = in_data.
  - row2 = row3 delayed by img_width in_clken events.
  - row1 = row2 delayed by img_width in_clken events.
- Delay pointer:
  - Advances only on in_clken.
  - Wraps from width-1 to 0 only on an in_clken cycle.
  - Holds when in_clken is low.
  - Each in_clken reads the old location and writes the new value at the pointer in the same cycle.
- Column shift: on in_clken, p{r}1 <= p{r}2, p{r}2 <= p{r}3, p{r}3 <= row{r}. Without in_clken, all taps hold.
- Counters: col_cnt (0..width-1) and row_cnt (saturating at 2).
  - Both clear on the in_vsync rising edge. The same edge latches width_q <= min(img_width, MAX_WIDTH).
  - col_cnt wraps on in_clken at width_q-1; row_cnt increments at that wrap.
- out_win_valid = registered (in_clken && row_cnt==2 && col_cnt>=2), evaluated before the counters update.
- Reset: all outputs, counters, taps and width_q go to 0. Delay storage is not cleared.
- Reset mid-frame: the block idles until the next in_vsync rising edge. Taps and outputs stay 0 until then.
- img_width changes mid-frame are ignored until the next frame.
- img_width < 2 is illegal and its behaviour is undefined. img_width > MAX_WIDTH is clipped.

## Timing
- Latency: an in_clken at cycle n produces the updated taps and out_clken at cycle n+1.
- p22 lags the input by one line plus one pixel.
- in_clken bursts and gaps are both legal. Output content depends only on in_clken events, not on cycle spacing.
- in_vsync rising edge coincident with in_clken: the counters clear first, and that pixel counts as col 0, row 0.

## Configuration
- WINDOW_BORDER_ZERO_EN defined: taps that would come from outside the current frame are forced to 0 at the output. This covers rows above row 0 and columns left of col 0.
- WINDOW_BORDER_ZERO_EN undefined: taps show raw buffer or shift contents, which may be stale data from the previous line or frame. Only out_win_valid marks validity.

## Structure
- Shared package image_sim_pkg holds:
  - DATA_W default.
  - MAX_WIDTH default.
  - Counter width constant CNT_W = 16.
- Sub-module line_delay_ram is instantiated twice:
  - Inputs: clock, rst_n, clken, length, din.
  - Output: dout.
  - Contains the wrap-on-clken pointer and the DATA_W × MAX_WIDTH array.

## Test plan
Common stimulus: img_width=4, pixel value = row*4+col+1 unless noted.
- Full window: stream 3 rows with continuous in_clken. At the cycle after pixel (row 2, col 2) = 11, the taps read p11..p33 = 1,2,3 / 5,6,7 / 9,10,11 and out_win_valid=1.
- Border zero (macro on): first pixel of the frame = 1 gives p33=1, all other taps 0, out_clken=1, out_win_valid=0. With the macro off, out_win_valid is still 0.
- Strobe gaps: same stream with in_clken every third cycle gives the identical tap sequence on out_clken cycles. Taps hold between strobes.
- Width latch: img_width changed 4→6 mid-frame leaves the wrap still at col 3. The next frame wraps at col 5.
- Reset mid-frame: rst_n low at row 1 col 2 forces all outputs to 0 asynchronously. After a new vsync, the first valid window appears at row 2 col 2 of the new frame.
- Clip: img_width=1000 with MAX_WIDTH=640 makes the line wrap at col 639.

Source files
------------

// File: rtl/image_sim_pkg.sv
// Shared constants, frame-state enum and width-clipping helper for the image pipeline blocks.
package image_sim_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_MAX_WIDTH = 640;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic {
        FRAME_IDLE   = 1'b0,
        FRAME_ACTIVE = 1'b1
    } frame_state_e;

    function automatic logic [CNT_W-1:0] clip_width(input logic [CNT_W-1:0] w,
                                                    input logic [CNT_W-1:0] max_w);
        return (w > max_w) ? max_w : w;
    endfunction

endpackage

// File: rtl/line_window_3x3_line_delay_ram.sv
// One line of pixel delay: circular buffer whose pointer advances and wraps only on clken.
module line_delay_ram
    import image_sim_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_WIDTH = DEF_MAX_WIDTH
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              clken,
    input  logic [CNT_W-1:0]  length,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    logic [DATA_W-1:0] mem [MAX_WIDTH];
    logic [AW-1:0]     ptr_q;
    logic [AW-1:0]     ptr_d;

    // ">=" rather than "==" so a pointer left beyond a shorter new length still returns to 0
    always_comb begin
        ptr_d = ptr_q;
        if (clken) begin
            if (CNT_W'(ptr_q) >= length - CNT_W'(1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (clken) begin
            mem[ptr_q] <= din;
        end
    end

    assign dout = mem[ptr_q];

endmodule

// File: rtl/line_window_3x3.sv
// 3x3 window generator: two cascaded line delays plus per-row column shift registers.
// Optional WINDOW_BORDER_ZERO_EN forces taps outside the current frame to zero.
module line_window_3x3
    import image_sim_pkg::*;
#(
    parameter int unsigned MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int unsigned DATA_W    = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [15:0]       img_width,
    input  logic              in_vsync,
    input  logic              in_href,
    input  logic              in_clken,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vsync,
    output logic              out_href,
    output logic              out_clken,
    output logic [DATA_W-1:0] p11,
    output logic [DATA_W-1:0] p12,
    output logic [DATA_W-1:0] p13,
    output logic [DATA_W-1:0] p21,
    output logic [DATA_W-1:0] p22,
    output logic [DATA_W-1:0] p23,
    output logic [DATA_W-1:0] p31,
    output logic [DATA_W-1:0] p32,
    output logic [DATA_W-1:0] p33,
    output logic              out_win_valid
);

    logic              vsync_q, vsync_d;
    frame_state_e      frame_q, frame_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic              ovs_q, ovs_d, ohr_q, ohr_d, ock_q, ock_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] tap_q [3][3];
    logic [DATA_W-1:0] tap_d [3][3];
    logic [DATA_W-1:0] win   [3][3];

    logic              rise, active, en;
    logic [CNT_W-1:0]  width_eff, col_cur;
    logic [1:0]        row_cur;
    logic [DATA_W-1:0] row1, row2;

    // The rising-edge pixel already sees cleared counters and the freshly latched width
    always_comb begin
        rise      = in_vsync & ~vsync_q;
        active    = rise | (frame_q == FRAME_ACTIVE);
        en        = in_clken & active;
        width_eff = rise ? clip_width(img_width, CNT_W'(MAX_WIDTH)) : width_q;
        col_cur   = rise ? '0 : col_q;
        row_cur   = rise ? '0 : row_q;
    end

    line_delay_ram #(.DATA_W(DATA_W), .MAX_WIDTH(MAX_WIDTH)) u_delay_row2 (
        .clock  (clock),
        .rst_n  (rst_n),
        .clken  (en),
        .length (width_eff),
        .din    (in_data),
        .dout   (row2)
    );

    line_delay_ram #(.DATA_W(DATA_W), .MAX_WIDTH(MAX_WIDTH)) u_delay_row1 (
        .clock  (clock),
        .rst_n  (rst_n),
        .clken  (en),
        .length (width_eff),
        .din    (row2),
        .dout   (row1)
    );

    always_comb begin
        vsync_d = in_vsync;
        frame_d = rise ? FRAME_ACTIVE : frame_q;
        width_d = width_eff;
        col_d   = col_cur;
        row_d   = row_cur;
        ovs_d   = in_vsync & active;
        ohr_d   = in_href & active;
        ock_d   = in_clken & active;
        valid_d = en && (row_cur == 2'd2) && (col_cur >= CNT_W'(2));
        tap_d   = tap_q;
        if (en) begin
            for (int unsigned r = 0; r < 3; r++) begin
                tap_d[r][0] = tap_q[r][1];
                tap_d[r][1] = tap_q[r][2];
            end
            tap_d[0][2] = row1;
            tap_d[1][2] = row2;
            tap_d[2][2] = in_data;
            if (col_cur == width_eff - CNT_W'(1)) begin
                col_d = '0;
                if (row_cur != 2'd2) begin
                    row_d = row_cur + 2'd1;
                end
            end else begin
                col_d = col_cur + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b1;
            frame_q <= FRAME_IDLE;
            width_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ovs_q   <= 1'b0;
            ohr_q   <= 1'b0;
            ock_q   <= 1'b0;
            valid_q <= 1'b0;
            tap_q   <= '{default: '0};
        end else begin
            vsync_q <= vsync_d;
            frame_q <= frame_d;
            width_q <= width_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ovs_q   <= ovs_d;
            ohr_q   <= ohr_d;
            ock_q   <= ock_d;
            valid_q <= valid_d;
            tap_q   <= tap_d;
        end
    end

`ifdef WINDOW_BORDER_ZERO_EN
    // Bit 0 covers the oldest row/column (needs index >= 2), bit 1 the middle one (needs >= 1)
    logic [1:0] zrow_q, zrow_d, zcol_q, zcol_d;
    logic [2:0] zrow_full, zcol_full;

    always_comb begin
        zrow_d = zrow_q;
        zcol_d = zcol_q;
        if (en) begin
            zrow_d = {row_cur == 2'd0, row_cur < 2'd2};
            zcol_d = {col_cur == '0, col_cur < CNT_W'(2)};
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            zrow_q <= '0;
            zcol_q <= '0;
        end else begin
            zrow_q <= zrow_d;
            zcol_q <= zcol_d;
        end
    end

    always_comb begin
        zrow_full = {1'b0, zrow_q};
        zcol_full = {1'b0, zcol_q};
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                win[r][c] = (zrow_full[r] | zcol_full[c]) ? '0 : tap_q[r][c];
            end
        end
    end
`else
    always_comb begin
        win = tap_q;
    end
`endif

    assign out_vsync     = ovs_q;
    assign out_href      = ohr_q;
    assign out_clken     = ock_q;
    assign out_win_valid = valid_q;
    assign p11 = win[0][0];
    assign p12 = win[0][1];
    assign p13 = win[0][2];
    assign p21 = win[1][0];
    assign p22 = win[1][1];
    assign p23 = win[1][2];
    assign p31 = win[2][0];
    assign p32 = win[2][1];
    assign p33 = win[2][2];

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed frame sequence with random pixels/gaps, checked against a pixel-history window model.
module tb_line_window_3x3;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [15:0] img_width;
    logic        in_vsync, in_href, in_clken;
    logic [7:0]  in_data;
    logic        out_vsync, out_href, out_clken, out_win_valid;
    logic [7:0]  p11, p12, p13, p21, p22, p23, p31, p32, p33;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pixel history, window contents and frame position
    bit m_active, m_vs_prev;
    int m_w, m_row, m_col;
    int hist[$];
    int mt[3][3];
    bit mk[3][3];
    bit mz[3][3];
    bit e_vs, e_hr, e_ck, e_val;

    line_window_3x3 #(.MAX_WIDTH(640), .DATA_W(8)) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .img_width     (img_width),
        .in_vsync      (in_vsync),
        .in_href       (in_href),
        .in_clken      (in_clken),
        .in_data       (in_data),
        .out_vsync     (out_vsync),
        .out_href      (out_href),
        .out_clken     (out_clken),
        .p11           (p11),
        .p12           (p12),
        .p13           (p13),
        .p21           (p21),
        .p22           (p22),
        .p23           (p23),
        .p31           (p31),
        .p32           (p32),
        .p33           (p33),
        .out_win_valid (out_win_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input int expv);
        n_total++;
        assert (obs === 32'(expv)) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    function automatic logic [31:0] tap_obs(input int r, input int c);
        case (r * 3 + c)
            0: return 32'(p11);
            1: return 32'(p12);
            2: return 32'(p13);
            3: return 32'(p21);
            4: return 32'(p22);
            5: return 32'(p23);
            6: return 32'(p31);
            7: return 32'(p32);
            default: return 32'(p33);
        endcase
    endfunction

    task automatic model_reset();
        m_active  = 1'b0;
        m_vs_prev = 1'b1;
        m_w = 0; m_row = 0; m_col = 0;
        hist.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                mt[r][c] = 0; mk[r][c] = 1'b1; mz[r][c] = 1'b0;
            end
        e_vs = 0; e_hr = 0; e_ck = 0; e_val = 0;
    endtask

    task automatic model_step(input bit vs, input bit hr, input bit ck, input int d, input int imgw);
        bit rise;
        bit en;
        int n;
        int nw;
        rise = vs && !m_vs_prev;
        m_vs_prev = vs;
        if (rise) begin
            nw = (imgw > 640) ? 640 : imgw;
            if (nw != m_w) hist.delete();
            m_w = nw; m_active = 1'b1; m_row = 0; m_col = 0;
        end
        e_vs  = vs && m_active;
        e_hr  = hr && m_active;
        e_ck  = ck && m_active;
        en    = ck && m_active;
        e_val = en && (m_row >= 2) && (m_col >= 2);
        if (en) begin
            n = hist.size();
            for (int r = 0; r < 3; r++) begin
                mt[r][0] = mt[r][1]; mk[r][0] = mk[r][1];
                mt[r][1] = mt[r][2]; mk[r][1] = mk[r][2];
            end
            mt[2][2] = d; mk[2][2] = 1'b1;
            mk[1][2] = (n >= m_w);
            mt[1][2] = (n >= m_w) ? hist[n - m_w] : 0;
            mk[0][2] = (n >= 2 * m_w);
            mt[0][2] = (n >= 2 * m_w) ? hist[n - 2 * m_w] : 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    mz[r][c] = (m_row < 2 - r) || (m_col < 2 - c);
            hist.push_back(d);
            if (hist.size() > 1280) void'(hist.pop_front());
            m_col++;
            if (m_col == m_w) begin
                m_col = 0;
                m_row++;
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] obs;
        check("out_vsync", 32'(out_vsync), int'(e_vs));
        check("out_href", 32'(out_href), int'(e_hr));
        check("out_clken", 32'(out_clken), int'(e_ck));
        check("out_win_valid", 32'(out_win_valid), int'(e_val));
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                obs = tap_obs(r, c);
`ifdef WINDOW_BORDER_ZERO_EN
                if (mz[r][c]) check($sformatf("p%0d%0d_border", r + 1, c + 1), obs, 0);
                else if (mk[r][c]) check($sformatf("p%0d%0d", r + 1, c + 1), obs, mt[r][c]);
`else
                if (mk[r][c]) check($sformatf("p%0d%0d", r + 1, c + 1), obs, mt[r][c]);
`endif
            end
    endtask

    task automatic step(input bit vs, input bit hr, input bit ck, input int d, input int imgw);
        in_vsync  = vs;
        in_href   = hr;
        in_clken  = ck;
        in_data   = d[7:0];
        img_width = imgw[15:0];
        model_step(vs, hr, ck, d, imgw);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic reset_midframe();
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_all();
        repeat (2) begin
            @(posedge clock);
            #1;
            compare_all();
        end
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input int imgw, input int imgw_late, input int nrows,
                             input int gap_mode, input bit directed, input int rst_at);
        int wl;
        int d;
        int ng;
        int cur;
        int exp9[9];
        exp9 = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        wl  = (imgw > 640) ? 640 : imgw;
        cur = imgw;
        repeat (2) step(0, 0, 0, 0, cur);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < wl; c++) begin
                ng = (gap_mode == 1) ? 2 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
                repeat (ng) step(1, 1, 0, int'($urandom_range(0, 255)), cur);
                d = directed ? (r * 4 + c + 1) : int'($urandom_range(0, 255));
                step(1, 1, 1, d, cur);
                if (directed && r == 0 && c == 0) begin
                    check("first_p33", 32'(p33), 1);
                    check("first_clken", 32'(out_clken), 1);
                    check("first_valid", 32'(out_win_valid), 0);
`ifdef WINDOW_BORDER_ZERO_EN
                    for (int k = 0; k < 8; k++)
                        check($sformatf("first_zero_tap%0d", k), tap_obs(k / 3, k % 3), 0);
`endif
                end
                if (directed && r == 2 && c == 2) begin
                    for (int k = 0; k < 9; k++)
                        check($sformatf("full_win_tap%0d", k), tap_obs(k / 3, k % 3), exp9[k]);
                    check("full_win_valid", 32'(out_win_valid), 1);
                end
                if (r * wl + c == rst_at) begin
                    reset_midframe();
                    return;
                end
            end
            step(1, 0, 0, 0, cur);
            cur = imgw_late;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_vsync  = 1'b0;
        in_href   = 1'b0;
        in_clken  = 1'b0;
        in_data   = '0;
        img_width = 16'd4;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        compare_all();
        rst_n = 1'b1;

        run_frame(4, 4, 4, 0, 1'b1, -1);
        run_frame(4, 6, 4, 1, 1'b1, -1);
        run_frame(4, 4, 3, 2, 1'b0, 6);
        repeat (3) step(1, 1, 1, int'($urandom_range(0, 255)), 4);
        run_frame(4, 4, 4, 0, 1'b0, -1);
        run_frame(6, 6, 4, 2, 1'b0, -1);
        run_frame(1000, 1000, 3, 0, 1'b0, -1);
        repeat (2) step(0, 0, 0, 0, 1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
